// File: rtl/cmp_pkg.sv
// cmp_pkg
//   Shared types for byte-serial compare logic.
//   BYTE_W       : width of one compared slice
//   scan_state_t : controller state encoding
//   cmp_result_t : one-hot magnitude result {equal, greater, less};
//                  all-zero means "no result yet"
package cmp_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    typedef struct packed {
        logic equal;
        logic greater;
        logic less;
    } cmp_result_t;

endpackage : cmp_pkg

// File: rtl/comparator_8bit.sv
// comparator_8bit
//   Combinational unsigned magnitude compare of two bytes.
//   i_a, i_b   : operands
//   o_equal    : i_a == i_b
//   o_greater  : i_a >  i_b
//   o_less     : i_a <  i_b
module comparator_8bit
    import cmp_pkg::*;
(
    input  logic [BYTE_W-1:0] i_a,
    input  logic [BYTE_W-1:0] i_b,
    output logic              o_equal,
    output logic              o_greater,
    output logic              o_less
);

    assign o_equal   = (i_a == i_b);
    assign o_greater = (i_a >  i_b);
    assign o_less    = (i_a <  i_b);

endmodule : comparator_8bit

// File: rtl/serial_word_comparator.sv
// serial_word_comparator
//   Compares two NUM_BYTES-byte unsigned words one byte per clock, MSB
//   first, stopping at the first differing byte. NUM_BYTES legal: 2..8.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   start    : compare request, sampled only while busy=0
//   a_word   : operand A, latched on accepted start
//   b_word   : operand B, latched on accepted start
//   busy     : scan in progress
//   done     : one-cycle pulse, result flags updated this cycle
//   equal    : A == B for last completed compare
//   greater  : A >  B for last completed compare
//   less     : A <  B for last completed compare
//
//   state | meaning
//   IDLE  | waiting for start; result flags hold last compare
//   SCAN  | examining byte r_idx of the latched operands
module serial_word_comparator
    import cmp_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [BYTE_W*NUM_BYTES-1:0] a_word,
    input  logic [BYTE_W*NUM_BYTES-1:0] b_word,
    output logic                        busy,
    output logic                        done,
    output logic                        equal,
    output logic                        greater,
    output logic                        less
);

    localparam int IDX_W = $clog2(NUM_BYTES);

    scan_state_t                           r_state;
    scan_state_t                           w_state_nxt;
    logic [IDX_W-1:0]                      r_idx;
    logic [IDX_W-1:0]                      w_idx_nxt;
    logic [NUM_BYTES-1:0][BYTE_W-1:0]      r_a;
    logic [NUM_BYTES-1:0][BYTE_W-1:0]      r_b;
    cmp_result_t                           r_result;
    cmp_result_t                           w_result_nxt;
    logic                                  r_done;
    logic                                  w_done_nxt;
    logic                                  w_load;

    logic [BYTE_W-1:0]                     w_a_byte;
    logic [BYTE_W-1:0]                     w_b_byte;
    logic                                  w_byte_eq;
    logic                                  w_byte_gt;
    logic                                  w_byte_lt;

    assign w_a_byte = r_a[r_idx];
    assign w_b_byte = r_b[r_idx];

    comparator_8bit u_cmp (
        .i_a       (w_a_byte),
        .i_b       (w_b_byte),
        .o_equal   (w_byte_eq),
        .o_greater (w_byte_gt),
        .o_less    (w_byte_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_done   <= w_done_nxt;
            r_result <= w_result_nxt;
        end
    end

    // Operands only load from IDLE, so a start during a scan cannot
    // disturb the bytes still being examined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
        end else if (w_load) begin
            r_a <= a_word;
            r_b <= b_word;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_done_nxt   = 1'b0;
        w_result_nxt = r_result;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_idx_nxt   = IDX_W'(NUM_BYTES - 1);
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                // Byte 0 always terminates, so idx never underflows.
                if (!w_byte_eq || (r_idx == '0)) begin
                    w_result_nxt.equal   = w_byte_eq;
                    w_result_nxt.greater = w_byte_gt;
                    w_result_nxt.less    = w_byte_lt;
                    w_done_nxt           = 1'b1;
                    w_state_nxt          = IDLE;
                end else begin
                    w_idx_nxt = r_idx - IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy    = (r_state == SCAN);
    assign done    = r_done;
    assign equal   = r_result.equal;
    assign greater = r_result.greater;
    assign less    = r_result.less;

endmodule : serial_word_comparator
